dmem_cache: RTL and testbench
=============================

# dmem_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage and a multi-cycle backing data memory. It takes the MEM-stage address, store data and read/write strobes, and returns load data combinationally on a hit. On a read miss or any store it raises `stall` to the hazard unit, which freezes the pipeline while a req/ack transaction runs on the memory side.

## Interface
- `INDEX_BITS`, 4: index width; the cache holds 2^INDEX_BITS one-word lines.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_adr`  in  32  byte address from EXMEM ALU result; bits [1:0] are ignored.
- `cpu_wdata`  in  32  store data from EXMEM.
- `cpu_read`  in  1  load strobe from EXMEM.
- `cpu_write`  in  1  store strobe from EXMEM.
- `cpu_rdata`  out  32  load data to MEMWB.
- `stall`  out  1  freeze request to the hazard unit; combinational.
- `mem_req`  out  1  backing-memory request; registered.
- `mem_we`  out  1  1 = write, 0 = read; registered.
- `mem_adr`  out  32  word-aligned address `{cpu_adr[31:2],2'b00}`; registered.
- `mem_wdata`  out  32  write data; registered.
- `mem_rdata`  in  32  read data, valid when `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle completion pulse.
- `hit_count`, `miss_count`  out  32  statistics counters (see Configuration).

## Operation
- Address split: index = `cpu_adr[INDEX_BITS+1:2]`; tag = `cpu_adr[31:INDEX_BITS+2]`. Each line stores one valid bit, one tag and one 32-bit data word.
- Hit means valid[index] is set and the stored tag equals the address tag. On a hit, `cpu_rdata` = stored data; otherwise `cpu_rdata` = 0.
- FSM states: IDLE, RFILL, WRITE, DONE.
- **IDLE**
  - `cpu_write` = 1: `stall` = 1; latch the request onto the mem_* outputs; go to WRITE.
  - Otherwise, `cpu_read` = 1 with a miss: `stall` = 1; go to RFILL.
  - Otherwise, `cpu_read` = 1 with a hit: `stall` = 0; stay in IDLE.
  - No request: `stall` = 0; stay in IDLE.
- **RFILL**
  - Drive `mem_req` = 1, `mem_we` = 0, and `stall` = 1.
  - On `mem_ack`: write valid, tag and `mem_rdata` into the line; go to DONE.
- **WRITE**
  - Drive `mem_req` = 1, `mem_we` = 1, and `stall` = 1.
  - On `mem_ack`: if the store address hits, update the line data; a miss does not allocate. Go to DONE.
- **DONE**
  - `stall` = 0. For a load, `cpu_rdata` = the filled word. Always go to IDLE.
  - The request present in this cycle is the one just completed and is never reissued.
- Simultaneous `cpu_read` and `cpu_write` is illegal. The store takes priority.
- mem_* outputs stay stable while `mem_req` = 1. `mem_ack` is ignored outside RFILL and WRITE.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req` 0, `mem_we` 0, `mem_adr` 0, `mem_wdata` 0, counters 0. `stall` is forced to 0 while `rst` = 1. `cpu_rdata` reads 0 because no line is valid.
- Read hit: zero stall cycles; data is valid in the same cycle.
- Read miss with ack latency L ≥ 1 cycles after `mem_req` rises: `stall` is high for 1 + L cycles, then DONE releases the pipeline.
- Store: same timing as a read miss, regardless of hit or miss.
- Reset mid-transaction: the transaction is abandoned, `mem_req` drops on the next edge, and any later `mem_ack` is ignored.
- `mem_ack` in the same cycle `mem_req` first rises counts as L = 1.

## Configuration
- Macro `DCACHE_STATS_EN`.
- Defined: `hit_count` increments on every IDLE read hit; `miss_count` increments on every IDLE→RFILL transition. Stores are not counted. Both counters wrap modulo 2^32 and are cleared by `rst`.
- Undefined: counter logic is removed; `hit_count` and `miss_count` remain as ports tied to 0 so instantiations are unchanged.

## Structure
- Shared package `dmem_pkg` holds the FSM state encoding (2 bits: IDLE=0, RFILL=1, WRITE=2, DONE=3) and the default `INDEX_BITS`.
- One sub-module, `dcache_array`: valid/tag/data storage with a combinational read port, one synchronous write port and a synchronous valid-clear on reset. Hit compare and FSM live in `dmem_cache`.

## Test plan
- Reset, then load 0x100, ack after 2 cycles with rdata 0xDEADBEEF → `stall` high for 3 cycles; DONE `cpu_rdata` = 0xDEADBEEF; `miss_count` = 1.
- Reload 0x100 → zero stall, `cpu_rdata` = 0xDEADBEEF, `hit_count` = 1, `mem_req` stays 0.
- Store 0x12345678 to 0x100 (hit), ack after 1 cycle → one write transaction with `mem_adr` = 0x100; subsequent load 0x100 hits with 0x12345678.
- Store to 0x200 (miss, index 0 shared with 0x100) → write issued; load 0x100 still hits with old data; load 0x200 misses.
- Load 0x140 (index 0, tag differs from 0x100) → miss and refill, evicting 0x100; next load 0x100 misses.
- Assert `rst` during RFILL → `mem_req` 0 next cycle; a late `mem_ack` is ignored; load 0x100 afterwards misses.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and default geometry for the data cache
package dmem_pkg;
  localparam int DEF_INDEX_BITS = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RFILL = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  function automatic logic [31:0] word_adr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, combinational read, one sync write, valid-clear on reset
module dcache_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through no-write-allocate data cache; DCACHE_STATS_EN enables hit/miss counters
module dmem_cache
  import dmem_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  logic [1:0]            state;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag, line_tag;
  logic                  line_valid, hit, arr_we, idle_miss;
  logic [31:0]           line_data;
  logic                  unused_adr_lsbs;
  assign unused_adr_lsbs = ^cpu_adr[1:0];
  assign idx       = cpu_adr[INDEX_BITS+1:2];
  assign tag       = cpu_adr[31:INDEX_BITS+2];
  assign hit       = line_valid && line_tag == tag;
  assign cpu_rdata = hit ? line_data : '0;
  assign idle_miss = state == S_IDLE && !cpu_write && cpu_read && !hit;
  always_comb begin
    stall  = rst ? 1'b0 :
             state == S_IDLE ? cpu_write || (cpu_read && !hit) :
             state == S_RFILL || state == S_WRITE;
    arr_we = mem_ack && (state == S_RFILL || (state == S_WRITE && hit));
  end
  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .we      (arr_we),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data (state == S_RFILL ? mem_rdata : mem_wdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_write) begin
            state     <= S_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_adr   <= word_adr(cpu_adr);
            mem_wdata <= cpu_wdata;
          end else if (idle_miss) begin
            state   <= S_RFILL;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_adr <= word_adr(cpu_adr);
          end
        end
        S_RFILL, S_WRITE: begin
          if (mem_ack) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == S_IDLE && !cpu_write && cpu_read && hit) hit_count <= hit_count + 32'd1;
      if (idle_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: directed self-checking bench for dmem_cache
module tb_dmem_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata, mem_adr, mem_wdata, mem_rdata, hit_count, miss_count;
  logic        cpu_read, cpu_write, stall, mem_req, mem_we, mem_ack;
  int total = 0;
  int bad = 0;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  always #5 clk = ~clk;
  dmem_cache dut (
    .clk(clk), .rst(rst), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
    @(negedge clk);
    rst = r; cpu_read = rd; cpu_write = wr; cpu_adr = a; cpu_wdata = wd;
    mem_ack = ack; mem_rdata = rdat;
    #1;
  endtask
  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction
  initial begin
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(1, 0, 0, 32'h0, 0, 0, 0);
    step(1, 1, 0, 32'h100, 0, 0, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    // first load misses: IDLE + two RFILL cycles stalled, DONE releases
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("miss_stall_c1", 32'(stall), 1);
    chk("miss_req_c1", 32'(mem_req), 0);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("miss_stall_c2", 32'(stall), 1);
    chk("fill_req", 32'(mem_req), 1);
    chk("fill_we", 32'(mem_we), 0);
    chk("fill_adr", mem_adr, 32'h100);
    step(0, 1, 0, 32'h100, 0, 1, 32'hDEADBEEF);
    chk("miss_stall_c3", 32'(stall), 1);
    chk("fill_req_hold", 32'(mem_req), 1);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("done_req", 32'(mem_req), 0);
    chk("miss_count1", miss_count, st(1));
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("hit_stall", 32'(stall), 0);
    chk("hit_rdata", cpu_rdata, 32'hDEADBEEF);
    step(0, 0, 1, 32'h100, 32'h12345678, 0, 0);
    chk("hit_count1", hit_count, st(1));
    chk("hit_req_idle", 32'(mem_req), 0);
    chk("st_stall_c1", 32'(stall), 1);
    step(0, 0, 1, 32'h100, 32'h12345678, 1, 0);
    chk("st_stall_c2", 32'(stall), 1);
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_adr", mem_adr, 32'h100);
    chk("st_wdata", mem_wdata, 32'h12345678);
    step(0, 0, 1, 32'h100, 32'h12345678, 0, 0);
    chk("st_done_stall", 32'(stall), 0);
    chk("st_done_req", 32'(mem_req), 0);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("st_hit_stall", 32'(stall), 0);
    chk("st_hit_rdata", cpu_rdata, 32'h12345678);
    // store miss to the shared index must not allocate
    step(0, 0, 1, 32'h203, 32'hCAFEF00D, 0, 0);
    chk("stm_stall_c1", 32'(stall), 1);
    step(0, 0, 1, 32'h203, 32'hCAFEF00D, 0, 0);
    chk("stm_adr", mem_adr, 32'h200);
    chk("stm_wdata", mem_wdata, 32'hCAFEF00D);
    step(0, 0, 1, 32'h203, 32'hCAFEF00D, 1, 0);
    chk("stm_stall_c3", 32'(stall), 1);
    step(0, 0, 1, 32'h203, 32'hCAFEF00D, 0, 0);
    chk("stm_done_stall", 32'(stall), 0);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("old_hit_stall", 32'(stall), 0);
    chk("old_hit_rdata", cpu_rdata, 32'h12345678);
    step(0, 1, 0, 32'h200, 0, 0, 0);
    chk("noalloc_stall", 32'(stall), 1);
    chk("noalloc_rdata", cpu_rdata, 0);
    chk("hit_count3", hit_count, st(3));
    step(0, 1, 0, 32'h200, 0, 1, 32'h0200DA7A);
    step(0, 1, 0, 32'h200, 0, 0, 0);
    chk("fill200_rdata", cpu_rdata, 32'h0200DA7A);
    // 0x140 shares index 0 with a different tag
    step(0, 1, 0, 32'h140, 0, 0, 0);
    chk("ld140_stall", 32'(stall), 1);
    step(0, 1, 0, 32'h140, 0, 1, 32'h00140140);
    chk("ld140_adr", mem_adr, 32'h140);
    step(0, 1, 0, 32'h140, 0, 0, 0);
    chk("ld140_rdata", cpu_rdata, 32'h00140140);
    chk("miss_count3", miss_count, st(3));
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("evict_stall", 32'(stall), 1);
    chk("evict_rdata", cpu_rdata, 0);
    // reset lands while the refill is outstanding
    step(1, 1, 0, 32'h100, 0, 0, 0);
    chk("rst_fill_stall", 32'(stall), 0);
    chk("rst_fill_req_before", 32'(mem_req), 1);
    step(0, 0, 0, 32'h100, 0, 1, 32'hBAADF00D);
    chk("rst_fill_req", 32'(mem_req), 0);
    chk("rst_fill_misses", miss_count, 0);
    chk("late_ack_stall", 32'(stall), 0);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("late_ack_req", 32'(mem_req), 0);
    chk("post_rst_stall", 32'(stall), 1);
    chk("post_rst_rdata", cpu_rdata, 0);
    step(0, 1, 0, 32'h100, 0, 0, 0);
    chk("post_rst_req", 32'(mem_req), 1);
    chk("post_rst_misses", miss_count, st(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
